// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start bit, 2-bit port, 4-bit length, payload
// MSB first, then GAP_BITS idle-high bits. Advances one bit per clkEn edge.
//
//   state | meaning
//   IDLE  | line high, waiting for start (accepted only on a clkEn edge)
//   START | driving the 0 start bit
//   ADDR  | driving port[1:0], MSB first
//   LEN   | driving len[3:0], MSB first
//   DATA  | driving data[len-1:0], MSB first
//   GAP   | driving GAP_BITS idle-high bits before returning to IDLE
module serial_frame_tx #(
  parameter int GAP_BITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        clkEn,
  input  logic        start,
  input  logic [1:0]  port,
  input  logic [3:0]  len,
  input  logic [14:0] data,
  output logic        SerOut,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {IDLE, START, ADDR, LEN, DATA, GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_BITS - 1);

  state_t      state, state_n;
  logic [3:0]  cnt, cnt_n, idx;
  logic [1:0]  port_q, port_n;
  logic [3:0]  len_q, len_n;
  logic [14:0] data_q, data_n;
  logic        ser_n, busy_n, done_n;

  // Next-state and next-output decode. cnt holds the number of bits still
  // to send in the current state after the one on the line; it is reloaded
  // on every state entry, so it never wraps within a state.
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    port_n  = port_q;
    len_n   = len_q;
    data_n  = data_q;
    ser_n   = SerOut;
    busy_n  = busy;
    done_n  = 1'b0;
    idx     = cnt - 4'd1;
    if (clkEn) begin
      case (state)
        IDLE: begin
          if (start) begin
            state_n = START;
            cnt_n   = 4'd0;
            port_n  = port;
            len_n   = len;
            data_n  = data;
            ser_n   = 1'b0;
            busy_n  = 1'b1;
          end
        end
        START: begin
          state_n = ADDR;
          cnt_n   = 4'd1;
          ser_n   = port_q[1];
        end
        ADDR: begin
          if (cnt != 4'd0) begin
            cnt_n = idx;
            ser_n = port_q[idx[0]];
          end else begin
            state_n = LEN;
            cnt_n   = 4'd3;
            ser_n   = len_q[3];
          end
        end
        LEN: begin
          if (cnt != 4'd0) begin
            cnt_n = idx;
            ser_n = len_q[idx[1:0]];
          end else if (len_q == 4'd0) begin
            state_n = GAP;
            cnt_n   = GAP_LAST;
            ser_n   = 1'b1;
          end else begin
            state_n = DATA;
            cnt_n   = len_q - 4'd1;
            ser_n   = data_q[len_q - 4'd1];
          end
        end
        DATA: begin
          if (cnt != 4'd0) begin
            cnt_n = idx;
            ser_n = data_q[idx];
          end else begin
            state_n = GAP;
            cnt_n   = GAP_LAST;
            ser_n   = 1'b1;
          end
        end
        GAP: begin
          ser_n = 1'b1;
          if (cnt != 4'd0) begin
            cnt_n = idx;
          end else begin
            state_n = IDLE;
            cnt_n   = 4'd0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          ser_n   = 1'b1;
          busy_n  = 1'b0;
        end
      endcase
    end
  end

  // State and registered outputs; reset wins over clkEn.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= 4'd0;
      port_q <= 2'd0;
      len_q  <= 4'd0;
      data_q <= 15'd0;
      SerOut <= 1'b1;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      port_q <= port_n;
      len_q  <= len_n;
      data_q <= data_n;
      SerOut <= ser_n;
      busy   <= busy_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_serial_frame_tx.sv
// Bench for serial_frame_tx: bit-level scoreboard of the expected line
// sequence plus a frame-level scoreboard checked against a loopback decoder.
module tb_serial_frame_tx;
  localparam int GAP = 2;

  logic        clk = 1'b0;
  logic        rst, clkEn, start;
  logic [1:0]  port;
  logic [3:0]  len;
  logic [14:0] data;
  logic        SerOut, busy, done;

  int total = 0;
  int bad   = 0;

  logic        exp_bits[$];
  logic [20:0] exp_frames[$];
  logic [20:0] rx_got[$];

  serial_frame_tx #(.GAP_BITS(GAP)) dut (
    .clk(clk), .rst(rst), .clkEn(clkEn), .start(start), .port(port),
    .len(len), .data(data), .SerOut(SerOut), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Loopback receiver: samples the line on clkEn edges, decodes one frame
  // {port, len, data} per start bit and records it.
  bit         rx_busy = 1'b0;
  int         rx_n, rx_need;
  logic [5:0] rx_hdr;
  logic [14:0] rx_sh;
  always @(posedge clk) begin
    if (rst) begin
      rx_busy = 1'b0;
    end else if (clkEn) begin
      if (!rx_busy) begin
        if (SerOut == 1'b0) begin
          rx_busy = 1'b1;
          rx_n    = 0;
          rx_need = 6;
          rx_sh   = '0;
          rx_hdr  = '0;
        end
      end else begin
        if (rx_n < 6) rx_hdr = {rx_hdr[4:0], SerOut};
        else          rx_sh  = {rx_sh[13:0], SerOut};
        rx_n++;
        if (rx_n == 6) rx_need = 6 + int'(rx_hdr[3:0]);
        if (rx_n == rx_need) begin
          rx_got.push_back({rx_hdr, rx_sh});
          rx_busy = 1'b0;
        end
      end
    end
  end

  function automatic logic [20:0] frame_word(input logic [1:0] p, input logic [3:0] l,
                                             input logic [14:0] d);
    logic [14:0] mask;
    mask = (15'd1 << l) - 15'd1;
    return {p, l, d & mask};
  endfunction

  task automatic push_bits(input logic [1:0] p, input logic [3:0] l, input logic [14:0] d);
    exp_bits.push_back(1'b0);
    exp_bits.push_back(p[1]);
    exp_bits.push_back(p[0]);
    for (int i = 3; i >= 0; i--) exp_bits.push_back(l[i]);
    for (int i = int'(l) - 1; i >= 0; i--) exp_bits.push_back(d[i]);
    for (int i = 0; i < GAP; i++) exp_bits.push_back(1'b1);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_rx(input string name);
    logic [20:0] want;
    want = exp_frames.pop_front();
    total++;
    if (rx_got.size() == 0) begin
      bad++;
      $display("FAIL %s rx frame: got none want %h", name, want);
    end else begin
      logic [20:0] got;
      got = rx_got.pop_front();
      if (got !== want) begin
        bad++;
        $display("FAIL %s rx frame: got %h want %h", name, got, want);
      end
    end
  endtask

  // One frame: each bit must stay on the line for div clks; optionally
  // re-asserts start with different inputs mid-frame.
  task automatic xmit(input logic [1:0] p, input logic [3:0] l, input logic [14:0] d,
                      input int div, input bit meddle, input string name);
    int   nbits;
    logic b;
    push_bits(p, l, d);
    exp_frames.push_back(frame_word(p, l, d));
    nbits = exp_bits.size();
    port = p; len = l; data = d; start = 1'b1; clkEn = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < nbits; i++) begin
      b = exp_bits.pop_front();
      for (int k = 0; k < div; k++) begin
        total++;
        if (SerOut !== b) begin
          bad++;
          $display("FAIL %s bit %0d clk %0d: SerOut got %b want %b", name, i, k, SerOut, b);
        end
        total++;
        if (busy !== 1'b1 || done !== 1'b0) begin
          bad++;
          $display("FAIL %s bit %0d clk %0d: busy/done got %b%b want 10", name, i, k, busy, done);
        end
        if (meddle && i == 5 && k == 0) begin
          start = 1'b1; port = ~p; len = ~l; data = ~d;
        end
        if (meddle && i == 6 && k == 0) start = 1'b0;
        clkEn = (k == div - 1);
        step();
      end
    end
    total++;
    if (done !== 1'b1 || busy !== 1'b0 || SerOut !== 1'b1) begin
      bad++;
      $display("FAIL %s end: done/busy/SerOut got %b%b%b want 101", name, done, busy, SerOut);
    end
    clkEn = 1'b0;
    step();
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++;
      $display("FAIL %s done fall: done/busy got %b%b want 00", name, done, busy);
    end
    check_rx(name);
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b1; clkEn = 1'b1; port = 2'd3; len = 4'd5; data = '1;
    step();
    step();
    total++;
    if (SerOut !== 1'b1) begin bad++; $display("FAIL reset SerOut: got %b want 1", SerOut); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset busy: got %b want 0", busy); end
    total++;
    if (done !== 1'b0) begin bad++; $display("FAIL reset done: got %b want 0", done); end
    rst = 1'b0; start = 1'b0;
    step();
    total++;
    if (busy !== 1'b0 || SerOut !== 1'b1) begin
      bad++;
      $display("FAIL reset release: busy/SerOut got %b%b want 01", busy, SerOut);
    end
    clkEn = 1'b0;
    step();
  endtask

  task automatic test_basic();
    xmit(2'd2, 4'd3, 15'b101, 1, 1'b0, "basic");
  endtask

  task automatic test_len0();
    xmit(2'd3, 4'd0, 15'h5555, 1, 1'b0, "len0");
  endtask

  task automatic test_clk_en_div();
    xmit(2'd1, 4'd15, 15'h7FFF, 4, 1'b0, "clken_div4");
  endtask

  task automatic test_start_ignored();
    xmit(2'd0, 4'd6, 15'h002D, 1, 1'b1, "start_ignored");
  endtask

  task automatic test_reset_mid();
    int ndone;
    port = 2'd0; len = 4'd8; data = 15'h00AB; start = 1'b1; clkEn = 1'b1;
    step();
    start = 1'b0;
    repeat (8) step();
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL reset_mid pre busy: got %b want 1", busy); end
    rst = 1'b1;
    step();
    rst = 1'b0;
    total++;
    if (SerOut !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid after rst: SerOut/busy/done got %b%b%b want 100", SerOut, busy, done);
    end
    ndone = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    total++;
    if (ndone != 0) begin bad++; $display("FAIL reset_mid done pulses: got %0d want 0", ndone); end
    total++;
    if (rx_got.size() != 0) begin
      bad++;
      $display("FAIL reset_mid rx frames: got %0d want 0", rx_got.size());
    end
    clkEn = 1'b0;
    step();
  endtask

  // With start held, each frame's GAP ones are followed by the single IDLE
  // period (done=1) on which the next start is accepted.
  task automatic test_back_to_back();
    int   n, ncyc, j, ndone;
    logic b;
    n = 7 + 2 + GAP;
    for (int f = 0; f < 3; f++) begin
      push_bits(2'd1, 4'd2, 15'h0002);
      exp_bits.push_back(1'b1);
      exp_frames.push_back(frame_word(2'd1, 4'd2, 15'h0002));
    end
    ncyc = exp_bits.size();
    ndone = 0;
    port = 2'd1; len = 4'd2; data = 15'h0002; start = 1'b1; clkEn = 1'b1;
    step();
    for (int c = 0; c < ncyc; c++) begin
      b = exp_bits.pop_front();
      j = c % (n + 1);
      total++;
      if (SerOut !== b) begin
        bad++;
        $display("FAIL b2b cycle %0d: SerOut got %b want %b", c, SerOut, b);
      end
      total++;
      if (done !== (j == n) || busy !== (j != n)) begin
        bad++;
        $display("FAIL b2b cycle %0d: done/busy got %b%b want %b%b", c, done, busy, j == n, j != n);
      end
      if (done === 1'b1) ndone++;
      if (c == ncyc - 1) start = 1'b0;
      step();
    end
    total++;
    if (ndone != 3 || busy !== 1'b0) begin
      bad++;
      $display("FAIL b2b end: dones got %0d busy %b want 3 and 0", ndone, busy);
    end
    clkEn = 1'b0;
    step();
    for (int f = 0; f < 3; f++) check_rx("b2b");
  endtask

  initial begin
    rst = 1'b1; clkEn = 1'b0; start = 1'b0; port = '0; len = '0; data = '0;
    test_reset();
    test_basic();
    test_len0();
    test_clk_en_div();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
